// File: rtl/rto_write_scheduler.sv
// rto_write_scheduler: round-robin, burst-bounded sharing of the RTO core
// FIFO write port. Accepted words must have strictly increasing timestamps.
// Ports: wr_clk/reset; req_valid/req_data/req_ready (producers);
// flush_req/fifo_full (in); write/fifo_din/flush (to core);
// grant_id/busy (status); error_clear/order_error* (error reporting).
module rto_write_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                         wr_clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*128-1:0]       req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush_req,
  input  logic                         fifo_full,
  output logic                         write,
  output logic [127:0]                 fifo_din,
  output logic                         flush,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  input  logic                         error_clear,
  output logic                         order_error,
  output logic [$clog2(NUM_REQ)-1:0]   order_error_id,
  output logic [127:0]                 order_error_data
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last_grant;
  logic [BW-1:0]   burst_cnt;
  logic [FW-1:0]   fl_cnt;
  logic [63:0]     last_ts;
  logic            last_ts_valid;

  logic [IW-1:0]   pick;
  logic            found;
  int              idx;
  logic [127:0]    gdata;
  logic            gvalid;
  logic            xfer;
  logic            ts_ok;
  logic            burst_end;

  assign gdata     = req_data[int'(grant_id)*128 +: 128];
  assign gvalid    = req_valid[grant_id];
  assign xfer      = (state == GRANT) && gvalid && !fifo_full && !flush_req;
  assign ts_ok     = !last_ts_valid || (gdata[127:64] > last_ts);
  assign burst_end = (burst_cnt == BW'(MAX_BURST - 1));

  // First valid requester after last_grant, wrapping around.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (flush_req)  state_nx = FLUSH;
        else if (found) state_nx = GRANT;
      end
      GRANT: begin
        if (flush_req)                state_nx = FLUSH;
        else if (!gvalid)             state_nx = IDLE;
        else if (xfer && burst_end)   state_nx = IDLE;
      end
      FLUSH: begin
        if (fl_cnt == FW'(FLUSH_CYCLES)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[grant_id] = !fifo_full && !flush_req;
    busy = (state != IDLE);
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      write            <= 1'b0;
      fifo_din         <= '0;
      flush            <= 1'b0;
      grant_id         <= '0;
      last_grant       <= IW'(NUM_REQ - 1);
      burst_cnt        <= '0;
      fl_cnt           <= '0;
      last_ts          <= '0;
      last_ts_valid    <= 1'b0;
      order_error      <= 1'b0;
      order_error_id   <= '0;
      order_error_data <= '0;
    end else begin
      write <= 1'b0;
      if (state == IDLE && !flush_req && found) begin
        grant_id   <= pick;
        last_grant <= pick;
        burst_cnt  <= '0;
      end
      // A rejection in the same cycle overrides the clear below.
      if (error_clear) order_error <= 1'b0;
      if (xfer) begin
        burst_cnt <= burst_cnt + BW'(1);
        if (ts_ok) begin
          write         <= 1'b1;
          fifo_din      <= gdata;
          last_ts       <= gdata[127:64];
          last_ts_valid <= 1'b1;
        end else begin
          order_error      <= 1'b1;
          order_error_id   <= grant_id;
          order_error_data <= gdata;
        end
      end
      // flush is high for the FLUSH_CYCLES cycles after entry.
      if (state == FLUSH) begin
        fl_cnt        <= fl_cnt + FW'(1);
        flush         <= (fl_cnt < FW'(FLUSH_CYCLES));
        last_ts_valid <= 1'b0;
      end else begin
        fl_cnt <= '0;
        flush  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rto_write_scheduler.sv
// tb_rto_write_scheduler: directed checks of rto_write_scheduler.
// Table vectors for order reject/clear, sequences for the rest.
module tb_rto_write_scheduler;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int FC = 4;

  logic              wr_clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*128-1:0] req_data;
  logic [NR-1:0]     req_ready;
  logic              flush_req;
  logic              fifo_full;
  logic              write;
  logic [127:0]      fifo_din;
  logic              flush;
  logic [1:0]        grant_id;
  logic              busy;
  logic              error_clear;
  logic              order_error;
  logic [1:0]        order_error_id;
  logic [127:0]      order_error_data;

  always #5 wr_clk = ~wr_clk;

  rto_write_scheduler #(
    .NUM_REQ(NR), .MAX_BURST(MB), .FLUSH_CYCLES(FC)
  ) dut (
    .wr_clk(wr_clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .flush_req(flush_req), .fifo_full(fifo_full),
    .write(write), .fifo_din(fifo_din), .flush(flush),
    .grant_id(grant_id), .busy(busy),
    .error_clear(error_clear), .order_error(order_error),
    .order_error_id(order_error_id),
    .order_error_data(order_error_data)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_writes = 0;

  logic [63:0]  qts [NR][16];
  int           qh [NR];
  int           qn [NR];
  logic [127:0] sb [$];

  typedef struct {
    logic [3:0]   valid;
    logic [63:0]  ts;
    logic         ec;
    logic [3:0]   e_ready;
    logic         e_write;
    logic [127:0] e_din;
    logic         e_busy;
    logic         e_err;
    logic [1:0]   e_eid;
    logic [127:0] e_edata;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] w(input logic [63:0] ts, input int r);
    return {ts, 64'(r)};
  endfunction

  function automatic vec_t mk(
    input logic [3:0] v, input logic [63:0] ts, input logic ec,
    input logic [3:0] rdy, input logic wr, input logic [127:0] din,
    input logic bsy, input logic err, input logic [1:0] eid,
    input logic [127:0] edata);
    vec_t t;
    t.valid = v; t.ts = ts; t.ec = ec; t.e_ready = rdy;
    t.e_write = wr; t.e_din = din; t.e_busy = bsy;
    t.e_err = err; t.e_eid = eid; t.e_edata = edata;
    return t;
  endfunction

  function automatic logic [127:0] cur_word(input int i);
    return {qts[i][qh[i]], 32'(i), 32'(qh[i])};
  endfunction

  task automatic push(input int i, input logic [63:0] ts);
    qts[i][qn[i]] = ts;
    qn[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (qh[i] < qn[i]);
      req_data[i*128 +: 128] = (qh[i] < qn[i]) ? cur_word(i) : '0;
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < NR; i++) begin
      qh[i] = 0;
      qn[i] = 0;
    end
    sb.delete();
    drive();
  endtask

  // One clock: note handshakes, then score any write after the edge.
  task automatic tick();
    logic [NR-1:0] xf;
    #4;
    xf = req_valid & req_ready;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (xf[i]) begin
        sb.push_back(cur_word(i));
        qh[i]++;
      end
    end
    if (write) begin
      n_writes++;
      if (sb.size() == 0) chk("unexpected_write", write, 1'b0);
      else chk("write_word", fifo_din, sb.pop_front());
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_req = 1'b0;
    fifo_full = 1'b0;
    error_clear = 1'b0;
    clear_q();
    repeat (2) @(posedge wr_clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = mk(4'b0100, 64'h100, 0, 4'b0000, 0, '0,
                1, 0, 2'd0, '0);
    tbl[1] = mk(4'b0100, 64'h100, 0, 4'b0100, 1, w(64'h100, 1),
                1, 0, 2'd0, '0);
    tbl[2] = mk(4'b0100, 64'h100, 0, 4'b0100, 0, w(64'h100, 1),
                1, 1, 2'd2, w(64'h100, 2));
    tbl[3] = mk(4'b0100, 64'h080, 1, 4'b0100, 0, w(64'h100, 1),
                1, 1, 2'd2, w(64'h080, 3));
    tbl[4] = mk(4'b0100, 64'h200, 1, 4'b0100, 1, w(64'h200, 4),
                0, 0, 2'd2, w(64'h080, 3));
    tbl[5] = mk(4'b0000, 64'h000, 0, 4'b0000, 0, w(64'h200, 4),
                0, 0, 2'd2, w(64'h080, 3));

    do_reset();
    chk("rst_write", write, 1'b0);
    chk("rst_din", fifo_din, '0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_gid", grant_id, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", order_error, 1'b0);
    chk("rst_eid", order_error_id, '0);
    chk("rst_edata", order_error_data, '0);
    chk("rst_ready", req_ready, '0);

    for (int r = 0; r < 6; r++) begin
      req_valid = tbl[r].valid;
      error_clear = tbl[r].ec;
      for (int i = 0; i < NR; i++)
        req_data[i*128 +: 128] = w(tbl[r].ts, r);
      #4;
      chk($sformatf("t%0d_ready", r), req_ready, tbl[r].e_ready);
      @(posedge wr_clk);
      #1;
      chk($sformatf("t%0d_write", r), write, tbl[r].e_write);
      chk($sformatf("t%0d_din", r), fifo_din, tbl[r].e_din);
      chk($sformatf("t%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("t%0d_err", r), order_error, tbl[r].e_err);
      chk($sformatf("t%0d_eid", r), order_error_id, tbl[r].e_eid);
      chk($sformatf("t%0d_edata", r), order_error_data, tbl[r].e_edata);
      chk($sformatf("t%0d_gid", r), grant_id, 2'd2);
    end
    error_clear = 1'b0;

    // Round robin, four words per grant, timestamps 1..64.
    do_reset();
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < NR; i++)
        push(i, 64'((k / 4) * 16 + i * 4 + (k % 4) + 1));
    drive();
    n_writes = 0;
    for (int e = 1; e <= 82; e++) begin
      tick();
      chk($sformatf("rr_write_e%0d", e), write,
          (e >= 2 && e <= 80 && e % 5 != 1));
      if (write) chk($sformatf("rr_grant_e%0d", e), grant_id, ((e - 2) / 5) % 4);
    end
    chk("rr_count", n_writes, 64);
    chk("rr_sb_empty", sb.size(), 0);

    // Backpressure mid-burst.
    do_reset();
    for (int k = 1; k <= 8; k++) push(0, 64'(k));
    drive();
    n_writes = 0;
    repeat (3) tick();
    chk("bp_pre_writes", n_writes, 2);
    fifo_full = 1'b1;
    #1;
    chk("bp_ready", req_ready, '0);
    begin
      int w0;
      w0 = n_writes;
      repeat (10) tick();
      chk("bp_stall_writes", n_writes - w0, 0);
    end
    chk("bp_grant", grant_id, 2'd0);
    chk("bp_busy", busy, 1'b1);
    fifo_full = 1'b0;
    repeat (12) tick();
    chk("bp_total", n_writes, 8);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_drained", qh[0], 8);

    // Flush during a burst, then a lower timestamp is accepted.
    do_reset();
    push(2, 64'h100);
    push(2, 64'h10);
    drive();
    n_writes = 0;
    tick();
    tick();
    chk("fl_first_write", write, 1'b1);
    flush_req = 1'b1;
    #1;
    chk("fl_ready_drop", req_ready, '0);
    tick();
    chk("fl_busy", busy, 1'b1);
    chk("fl_flush_entry", flush, 1'b0);
    flush_req = 1'b0;
    for (int e = 4; e <= 8; e++) begin
      tick();
      chk($sformatf("fl_flush_e%0d", e), flush, (e <= 7));
    end
    chk("fl_idle", busy, 1'b0);
    repeat (4) tick();
    chk("fl_writes", n_writes, 2);
    chk("fl_err", order_error, 1'b0);
    chk("fl_din_ts", fifo_din[127:64], 64'h10);
    chk("fl_sb_empty", sb.size(), 0);

    // Async reset between edges in the middle of a burst.
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 64'h500 + 64'(k));
    drive();
    n_writes = 0;
    repeat (3) tick();
    chk("ar_pre_writes", n_writes, 2);
    chk("ar_pre_gid", grant_id, 2'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_write", write, 1'b0);
    chk("ar_din", fifo_din, '0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_gid", grant_id, '0);
    chk("ar_ready", req_ready, '0);
    chk("ar_flush", flush, 1'b0);
    clear_q();
    @(posedge wr_clk);
    #1;
    reset = 1'b0;
    push(0, 64'h1);
    push(3, 64'h2);
    drive();
    n_writes = 0;
    tick();
    chk("ar_first_grant", grant_id, 2'd0);
    chk("ar_first_busy", busy, 1'b1);
    repeat (6) tick();
    chk("ar_writes", n_writes, 2);
    chk("ar_sb_empty", sb.size(), 0);
    chk("ar_err", order_error, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rto_write_scheduler.md
# rto_write_scheduler

- Shares the single write port of one RTO core FIFO among `NUM_REQ` 128-bit event producers.
- Each event word is {timestamp[127:64], payload[63:0]}.
- Arbitration is round-robin with bounded bursts; words enter the FIFO in strictly increasing timestamp order.
- Sequences FIFO flushes and reports ordering errors.
- Sits in the `wr_clk` domain, between the host command decoders and the core's `write`/`fifo_din`/`flush`/`full` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum words one requester transfers per grant, ≥1.
- `FLUSH_CYCLES`, 4: length of the `flush` pulse in cycles, ≥1.
- `wr_clk` in 1: the one clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in NUM_REQ: requester i has a word.
- `req_data` in NUM_REQ*128: word of requester i at bits [128*i+127:128*i].
- `req_ready` out NUM_REQ: combinational; a transfer happens when `req_valid[i] && req_ready[i]`.
- `flush_req` in 1: level request to flush the FIFO.
- `fifo_full` in 1: the core's programmable-full flag.
- `write` out 1: registered write strobe to the core.
- `fifo_din` out 128: registered word to the core.
- `flush` out 1: registered flush to the core.
- `grant_id` out $clog2(NUM_REQ): current or last granted requester.
- `busy` out 1: state ≠ IDLE.
- `error_clear` in 1: clears the sticky order error.
- `order_error` out 1: sticky; a word was rejected for out-of-order timestamp.
- `order_error_id` out $clog2(NUM_REQ): requester of the most recent rejected word.
- `order_error_data` out 128: most recent rejected word.

## Operation
- Reset values:
  - state = IDLE.
  - All outputs = 0.
  - Round-robin pointer `last_grant` = NUM_REQ-1, so requester 0 is checked first.
  - `last_ts` = 0, `last_ts_valid` = 0, `burst_cnt` = 0.
- FSM states: IDLE, GRANT, FLUSH.
- IDLE:
  - If `flush_req`, go to FLUSH.
  - Otherwise, if any `req_valid`, grant the first valid requester searching from `last_grant+1` with wrap. Register `grant_id` and `last_grant`, clear `burst_cnt`, go to GRANT.
  - `req_ready` = 0 in this state.
- GRANT:
  - `req_ready[grant_id]` = `~fifo_full && ~flush_req`; all other ready bits are 0.
  - On each transfer, `burst_cnt` increments.
  - Exit to IDLE when either:
    - a transfer occurs with `burst_cnt == MAX_BURST-1`, or
    - the granted `req_valid` is low.
  - If `flush_req` is high, go to FLUSH immediately; no transfer occurs in that cycle.
  - `fifo_full` alone holds the grant: ready is low and the state does not change.
- Order check, applied to every transferred word with ts = data[127:64]:
  - Accept if `~last_ts_valid` or ts > `last_ts` (unsigned 64-bit compare). On accept: next cycle `write`=1 and `fifo_din`=word; set `last_ts`=ts and `last_ts_valid`=1.
  - Reject otherwise. On reject: the word is still consumed and counts toward the burst. `write` stays 0. Set `order_error`=1 and capture `order_error_id` and `order_error_data`.
- `error_clear` clears `order_error` only; the captured id and data hold. A new rejection in the same cycle wins, so `order_error` stays 1.
- FLUSH:
  - `flush`=1 for exactly FLUSH_CYCLES cycles, starting the cycle after entry.
  - Clears `last_ts_valid`.
  - Then go to IDLE. If `flush_req` is still high, IDLE re-enters FLUSH.
  - No `req_ready` is asserted during FLUSH.
- `write` is high only in the cycle after an accepted transfer; otherwise 0. `fifo_din` holds its last value.
- Async `reset` mid-burst or mid-flush:
  - Immediately: state returns to IDLE and all outputs go to 0.
  - The in-flight word is lost.

## Timing
- Transfer accepted in cycle N: `write`/`fifo_din` valid in cycle N+1.
- Arbitration costs one IDLE cycle per grant, so steady throughput for one requester is MAX_BURST words per MAX_BURST+1 cycles.
- `fifo_full` is sampled combinationally into `req_ready`. At most one write lands after `full` rises, which the core's programmable threshold absorbs.
- `flush_req` rising in cycle N (state GRANT or IDLE):
  - FLUSH is entered at N+1.
  - `flush` is high for cycles N+2 .. N+1+FLUSH_CYCLES.
  - IDLE follows after that.
- `order_error` rises the cycle after the rejected transfer. `error_clear` takes effect the cycle after it is sampled.

## Test plan
- Round-robin: all 4 requesters are valid with increasing timestamps 1..64 interleaved, MAX_BURST=4. Required: grants go 0,1,2,3,0…; 4 writes per grant; one idle cycle between grants; `fifo_din` timestamps are strictly increasing.
- Backpressure: `fifo_full`=1 for 10 cycles mid-burst. Required: no `write` during the stall beyond the single word already accepted; grant holds; the burst resumes with no word lost or duplicated.
- Order reject: requester 2 sends ts=0x100 then ts=0x100. Required: one write; `order_error`=1, `order_error_id`=2, `order_error_data` = the second word. `error_clear` clears the flag; data is held.
- Flush: `flush_req` pulses during a burst, FLUSH_CYCLES=4. Required: ready drops the same cycle; `flush` is high for 4 cycles; a following ts=0x10 is accepted even though `last_ts` was 0x100.
- Simultaneous: `error_clear` and a rejected transfer in the same cycle. Required: `order_error` stays 1.
- Async reset asserted mid-burst, between clock edges. Required: outputs are 0 immediately; after release, the first grant goes to requester 0 and the first word is accepted regardless of timestamp.
